// File: rtl/sram_pkg.sv
// Purpose: shared definitions for the SRAM burst controller (FSM states, default geometry, width helpers).
// Latency: n/a (package only).
// Backpressure: n/a.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_SRAM_DW  = 16;
    localparam int DEF_SRAM_AW  = 18;
    localparam int DEF_WAIT_CYC = 3;

    // Counter width for a 0..n-1 counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Purpose: beat/wait counters for one SRAM burst; w counts clocks within a beat, b counts beats.
// Latency: counters advance one step per enabled clock; beat_last/xfer_last decode the current count.
// Backpressure: none; clear has priority over enable.
// Ports: clk, rst (async, active-high), clear, enable -> w, b, beat_last (w at last clock of a beat),
//        xfer_last (last clock of the last beat).
module sram_beat_timer
    import sram_pkg::*;
#(
    parameter  int BEATS    = 4,
    parameter  int WAIT_CYC = 3,
    localparam int BW       = cnt_w(BEATS),
    localparam int WW       = cnt_w(WAIT_CYC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic [WW-1:0] w,
    output logic [BW-1:0] b,
    output logic          beat_last,
    output logic          xfer_last
);

    localparam logic [WW-1:0] W_MAX = WW'(WAIT_CYC - 1);
    localparam logic [BW-1:0] B_MAX = BW'(BEATS - 1);

    logic [WW-1:0] w_q, w_d;
    logic [BW-1:0] b_q, b_d;

    assign beat_last = (w_q == W_MAX);
    assign xfer_last = beat_last && (b_q == B_MAX);
    assign w         = w_q;
    assign b         = b_q;

    always_comb begin
        w_d = w_q;
        b_d = b_q;
        if (clear) begin
            w_d = '0;
            b_d = '0;
        end else if (enable) begin
            if (beat_last) begin
                w_d = '0;
                b_d = (b_q == B_MAX) ? '0 : b_q + 1'b1;
            end else begin
                w_d = w_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
            b_q <= '0;
        end else begin
            w_q <= w_d;
            b_q <= b_d;
        end
    end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Purpose: converts one DATA_W read/write request into BEATS little-endian SRAM beats of WAIT_CYC clocks each.
// Latency: ready returns BEATS*WAIT_CYC+1 clocks after the request is first presented in IDLE (13 by default).
// Backpressure: requester holds rd_en/wr_en, addr and wr_data until ready; ready is low while busy.
// Ports: clk, rst (async, active-high); rd_en, wr_en, addr, wr_data from requester; rd_data, ready back;
//        sram_addr, sram_dq (bidirectional), active-low sram_we_n/ce_n/oe_n/ub_n/lb_n to the SRAM.
module sram_burst_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SRAM_DW  = DEF_SRAM_DW,
    parameter int SRAM_AW  = DEF_SRAM_AW,
    parameter int WAIT_CYC = DEF_WAIT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic [DATA_W-1:0]  rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_we_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int BEATS = DATA_W / SRAM_DW;
    localparam int BSH   = $clog2(SRAM_DW / 8);
    localparam int BW    = cnt_w(BEATS);
    localparam int WW    = cnt_w(WAIT_CYC);

    // Bursts are aligned to BEATS words so base+b never carries out of the block.
    localparam logic [SRAM_AW-1:0] BASE_MASK = ~SRAM_AW'(BEATS - 1);
    // we_n rises on the last clock of each beat; it is registered, so decode one clock early.
    localparam logic [WW-1:0]      W_PEN     = WW'(WAIT_CYC - 2);

    if (DATA_W % SRAM_DW != 0) begin : g_bad_width
        $error("sram_burst_ctrl: DATA_W must be a multiple of SRAM_DW");
    end
    if (!is_pow2(BEATS)) begin : g_bad_beats
        $error("sram_burst_ctrl: DATA_W/SRAM_DW must be a power of two");
    end
    if (WAIT_CYC < 2) begin : g_bad_wait
        $error("sram_burst_ctrl: WAIT_CYC must be at least 2");
    end

    state_t               state_q;
    logic                 we_n_q, oe_n_q, ce_n_q;
    logic [SRAM_AW-1:0]   sram_addr_q;
    logic [DATA_W-1:0]    rd_data_q;
    logic [SRAM_AW-1:0]   base;
    logic [WW-1:0]        w;
    logic [BW-1:0]        b;
    logic                 beat_last, xfer_last;
    logic [SRAM_DW-1:0]   dq_out;
    logic                 unused_addr;

    assign base        = addr[SRAM_AW+BSH-1:BSH] & BASE_MASK;
    assign unused_addr = ^addr;

    sram_beat_timer #(
        .BEATS    (BEATS),
        .WAIT_CYC (WAIT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q == DONE),
        .enable    ((state_q == READ) || (state_q == WRITE)),
        .w         (w),
        .b         (b),
        .beat_last (beat_last),
        .xfer_last (xfer_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            sram_addr_q <= '0;
            rd_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A read wins when both requests are present.
                    if (rd_en) begin
                        state_q     <= READ;
                        ce_n_q      <= 1'b0;
                        oe_n_q      <= 1'b0;
                        sram_addr_q <= base;
                    end else if (wr_en) begin
                        state_q     <= WRITE;
                        ce_n_q      <= 1'b0;
                        we_n_q      <= 1'b0;
                        sram_addr_q <= base;
                    end
                end
                READ: begin
                    if (beat_last) begin
                        rd_data_q[int'(b)*SRAM_DW +: SRAM_DW] <= sram_dq;
                    end
                    if (xfer_last) begin
                        state_q     <= DONE;
                        ce_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        sram_addr_q <= '0;
                    end else if (beat_last) begin
                        sram_addr_q <= sram_addr_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (xfer_last) begin
                        state_q     <= DONE;
                        ce_n_q      <= 1'b1;
                        we_n_q      <= 1'b1;
                        sram_addr_q <= '0;
                    end else begin
                        if (beat_last) begin
                            sram_addr_q <= sram_addr_q + 1'b1;
                        end
                        we_n_q <= (w == W_PEN);
                    end
                end
                DONE: begin
                    // Requests are not sampled here; a held request is taken from IDLE next cycle.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dq_out    = wr_data[int'(b)*SRAM_DW +: SRAM_DW];
    assign sram_dq   = (state_q == WRITE) ? dq_out : 'z;

    assign ready     = (state_q == DONE) || ((state_q == IDLE) && !rd_en && !wr_en);
    assign rd_data   = rd_data_q;
    assign sram_addr = sram_addr_q;
    assign sram_we_n = we_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_ce_n = ce_n_q;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Purpose: self-checking bench for sram_burst_ctrl with an SRAM model and a word-level reference memory.
// Latency: expects ready BEATS*WAIT_CYC+1 clocks after a request is presented in IDLE.
// Backpressure: requests are held until ready, then dropped for one IDLE cycle unless a test holds them.
module tb_sram_burst_ctrl;

    localparam int DW  = 64;
    localparam int SDW = 16;
    localparam int AW  = 18;
    localparam int WC  = 3;
    localparam int NB  = DW / SDW;
    localparam int LAT = NB * WC + 1;
    localparam logic [SDW-1:0] PROBE = 16'hA5C3;

    logic            clk = 1'b0;
    logic            rst;
    logic            rd_en, wr_en;
    logic [31:0]     addr;
    logic [DW-1:0]   wr_data, rd_data;
    logic            ready;
    logic [AW-1:0]   sram_addr;
    wire  [SDW-1:0]  sram_dq;
    logic            sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

    int n_checks = 0;
    int n_fail   = 0;

    // SRAM behavioural model: drives on read, captures on clock while we_n low.
    // With the chip deselected the bench drives a probe pattern; it reads back intact only if the DUT is released.
    logic [SDW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
    logic            model_oe;
    assign model_oe = !sram_ce_n && !sram_oe_n && sram_we_n;
    assign sram_dq  = model_oe ? mem[sram_addr] : (sram_ce_n ? PROBE : 'z);

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq;
    end

    always #5 clk = ~clk;

    sram_burst_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .ready     (ready),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_we_n (sram_we_n),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

    // Reference: word-addressed memory and the expected rd_data register.
    logic [SDW-1:0] ref_mem [int unsigned];
    logic [DW-1:0]  exp_rd;

    function automatic logic [SDW-1:0] ref_word(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    // Byte address -> SRAM word address, truncated to AW bits and aligned to a whole burst.
    function automatic int unsigned ref_base(input logic [31:0] a);
        int unsigned wa;
        wa = (a / (SDW / 8)) % (1 << AW);
        return wa - (wa % NB);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction from an IDLE negedge; returns at the following IDLE negedge.
    task automatic run_xfer(input bit r, input bit w, input logic [31:0] a, input logic [DW-1:0] d,
                            input string tag, output logic [AW-1:0] first_addr, output bit read_seen);
        int unsigned base;
        int lat, beat, ph, addr_err, we_err, oe_err, dq_err, mem_err;
        bit is_rd;
        is_rd = r;
        base = ref_base(a);
        first_addr = '0; read_seen = 1'b0;
        addr_err = 0; we_err = 0; oe_err = 0; dq_err = 0; mem_err = 0;
        rd_en = r; wr_en = w; addr = a; wr_data = d;
        #1;
        check({tag, " ready on accept"}, 64'(ready), 64'(0));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!ready && lat <= NB * WC) begin
                beat = (lat - 1) / WC;
                ph   = (lat - 1) % WC;
                if (lat == 1) begin
                    first_addr = sram_addr;
                    read_seen  = !sram_oe_n;
                end
                if (sram_addr !== AW'(base + beat) || sram_ce_n !== 1'b0) addr_err++;
                if (sram_we_n !== (is_rd || ph == WC - 1)) we_err++;
                if (sram_oe_n !== !is_rd) oe_err++;
                if (is_rd) begin
                    if (sram_dq !== ref_word(base + beat)) dq_err++;
                end else if (sram_dq !== d[beat*SDW +: SDW]) begin
                    dq_err++;
                end
            end
        end while (!ready && lat < 4 * LAT);
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        if (is_rd) begin
            for (int i = 0; i < NB; i++) exp_rd[i*SDW +: SDW] = ref_word(base + i);
        end else begin
            for (int i = 0; i < NB; i++) ref_mem[base + i] = d[i*SDW +: SDW];
        end
        for (int i = 0; i < NB; i++) if (mem[base + i] !== ref_word(base + i)) mem_err++;
        check({tag, " sram_addr sequence"}, 64'(addr_err), 64'(0));
        check({tag, " we_n pattern"}, 64'(we_err), 64'(0));
        check({tag, " oe_n pattern"}, 64'(oe_err), 64'(0));
        check({tag, " dq contents"}, 64'(dq_err), 64'(0));
        check({tag, " sram words"}, 64'(mem_err), 64'(0));
        check({tag, " rd_data"}, rd_data, exp_rd);
        check({tag, " done ce/we/oe/dq"}, {sram_ce_n, sram_we_n, sram_oe_n, sram_dq === PROBE}, 64'b1111);
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check({tag, " idle ready/addr"}, {ready, sram_addr == '0}, 64'b11);
    endtask

    typedef struct {
        bit            rd;
        bit            wr;
        logic [31:0]   a;
        logic [DW-1:0] d;
        logic [AW-1:0] exp_addr;
        bit            exp_read;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t          vecs [7];
    logic [AW-1:0] fa, la;
    bit            rs;
    int            lat;
    int            kind;
    logic [31:0]   ra;
    logic [DW-1:0] rdw;

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0; exp_rd = '0;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 64'h1122_3344_5566_7788, 18'h00080, 1'b0, 64'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0104, 64'h0,                   18'h00080, 1'b1, 64'h1122_3344_5566_7788};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 64'hDEAD_BEEF_CAFE_F00D, 18'h00080, 1'b1, 64'h1122_3344_5566_7788};
        vecs[3] = '{1'b0, 1'b1, 32'h0003_FFF8, 64'hAAAA_BBBB_CCCC_DDDD, 18'h1FFFC, 1'b0, 64'h1122_3344_5566_7788};
        vecs[4] = '{1'b1, 1'b0, 32'h0003_FFF8, 64'h0,                   18'h1FFFC, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD};
        vecs[5] = '{1'b0, 1'b1, 32'h0010_0027, 64'h0102_0304_0506_0708, 18'h00010, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0020, 64'h0,                   18'h00010, 1'b1, 64'h0102_0304_0506_0708};

        repeat (2) @(negedge clk);
        check("reset ready", 64'(ready), 64'(1));
        check("reset we/oe/ce/ub/lb", {sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 64'b11100);
        check("reset sram_addr", 64'(sram_addr), 64'(0));
        check("reset rd_data", rd_data, 64'(0));
        check("reset dq released", 64'(sram_dq === PROBE), 64'(1));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, $sformatf("vec%0d", i), fa, rs);
            check($sformatf("vec%0d base addr", i), 64'(fa), 64'(vecs[i].exp_addr));
            check($sformatf("vec%0d read chosen", i), 64'(rs), 64'(vecs[i].exp_read));
            check($sformatf("vec%0d rd_data table", i), rd_data, vecs[i].exp_rdata);
        end
        check("sram word 0x80", 64'(mem[18'h80]), 64'h7788);
        check("sram word 0x81", 64'(mem[18'h81]), 64'h5566);
        check("sram word 0x82", 64'(mem[18'h82]), 64'h3344);
        check("sram word 0x83", 64'(mem[18'h83]), 64'h1122);

        // Read held through DONE: one IDLE cycle with ready low, then a second burst.
        rd_en = 1'b1; wr_en = 1'b0; addr = 32'h0003_FFF8;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ready && lat < 4 * LAT);
        check("held first latency", 64'(lat), 64'(LAT));
        @(negedge clk);
        check("held idle gap ready/ce_n", {ready, sram_ce_n}, 64'b01);
        lat = 0; fa = '0; la = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) fa = sram_addr;
            if (lat == LAT - 1) la = sram_addr;
        end while (!ready && lat < 4 * LAT);
        check("held second latency", 64'(lat), 64'(LAT));
        check("held first addr", 64'(fa), 64'h1FFFC);
        check("held last addr", 64'(la), 64'h1FFFF);
        check("held rd_data", rd_data, 64'hAAAA_BBBB_CCCC_DDDD);
        exp_rd = 64'hAAAA_BBBB_CCCC_DDDD;
        rd_en = 1'b0;
        @(negedge clk);

        // Reset during beat 2 of a write.
        wr_en = 1'b1; addr = 32'h0000_0200; wr_data = 64'h9999_8888_7777_6666;
        repeat (7) @(negedge clk);
        check("rst beat2 addr", 64'(sram_addr), 64'h102);
        check("rst beat2 we_n", 64'(sram_we_n), 64'(0));
        rst = 1'b1;
        #1;
        check("rst we/ce/oe", {sram_we_n, sram_ce_n, sram_oe_n}, 64'b111);
        check("rst dq released", 64'(sram_dq === PROBE), 64'(1));
        check("rst sram_addr", 64'(sram_addr), 64'(0));
        check("rst rd_data", rd_data, 64'(0));
        exp_rd = '0;
        wr_en = 1'b0;
        #1;
        check("rst ready", 64'(ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst idle ready", 64'(ready), 64'(1));
        ref_mem[32'h100] = 16'h6666;
        ref_mem[32'h101] = 16'h7777;
        run_xfer(1'b1, 1'b0, 32'h0000_0200, '0, "post-rst read", fa, rs);
        check("post-rst partial data", rd_data, 64'h0000_0000_7777_6666);

        // Random traffic over a small region so reads hit earlier writes.
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            ra   = $urandom & 32'hFFF8_00FF;
            rdw  = {$urandom, $urandom};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_xfer(kind != 2, kind >= 2, ra, rdw, $sformatf("rand%0d", i), fa, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_burst_ctrl.md
SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 SHALL take parameter DATA_W, default 64: requester data width; integer multiple of SRAM_DW.
REQ-002 SHALL take parameter SRAM_DW, default 16: SRAM data-bus width.
REQ-003 SHALL take parameter SRAM_AW, default 18: SRAM word-address width.
REQ-004 SHALL take parameter WAIT_CYC, default 3: clocks per SRAM beat; legal values are 2 and above.
REQ-005 SHALL derive BEATS = DATA_W/SRAM_DW and BSH = log2(SRAM_DW/8) as localparams.
REQ-006 clk  in  1  clock; rising-edge only.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 rd_en  in  1  read request; held until ready.
REQ-009 wr_en  in  1  write request; held until ready.
REQ-010 addr  in  32  byte address; low log2(DATA_W/8) bits ignored.
REQ-011 wr_data  in  DATA_W  write data; held stable until ready.
REQ-012 rd_data  out  DATA_W  read result; registered.
REQ-013 ready  out  1  idle/transaction-complete.
REQ-014 sram_addr  out  SRAM_AW  SRAM word address.
REQ-015 sram_dq  inout  SRAM_DW  SRAM data bus.
REQ-016 sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM controls.

Function
REQ-017 SHALL use FSM states IDLE, READ, WRITE, DONE.
REQ-018 In IDLE: rd_en -> READ; else wr_en -> WRITE; else stay. rd_en and wr_en together SHALL perform a read only.
REQ-019 READ and WRITE SHALL each last exactly BEATS*WAIT_CYC cycles, then go to DONE; DONE SHALL last 1 cycle, then go to IDLE.
REQ-020 Requests SHALL be ignored in DONE; a held request starts a new transaction from IDLE on the following cycle.
REQ-021 ready SHALL be high in IDLE with no request, high in DONE, and low otherwise (including the IDLE cycle that accepts a request).
REQ-022 Latency: ready SHALL assert BEATS*WAIT_CYC+1 cycles after the accepting IDLE edge (13 with defaults).
REQ-023 Beat counter b (0..BEATS-1) and wait counter w (0..WAIT_CYC-1): w wraps at WAIT_CYC-1 and increments b; both cleared on entry to IDLE.
REQ-024 sram_addr SHALL be base + b, where base = addr[SRAM_AW+BSH-1:BSH] with its low log2(BEATS) bits forced to 0. It is 0 in IDLE and wraps modulo 2^SRAM_AW.
REQ-025 Beat b SHALL carry data slice [b*SRAM_DW +: SRAM_DW] (little-endian beat order).
REQ-026 WRITE: sram_dq SHALL be driven with the current slice; sram_we_n low for w = 0..WAIT_CYC-2 and high at w = WAIT_CYC-1.
REQ-027 READ: sram_oe_n low; the slice SHALL be captured into rd_data at w = WAIT_CYC-1.
REQ-028 rd_data SHALL hold its value until the next read overwrites it; writes SHALL NOT alter it.
REQ-029 sram_ce_n SHALL be low in READ/WRITE and high otherwise; sram_ub_n and sram_lb_n SHALL be tied low.
REQ-030 sram_dq SHALL be high-Z in every state except WRITE.

Reset
REQ-031 rst SHALL immediately force state IDLE, counters 0, rd_data 0, sram_addr 0, we_n/oe_n/ce_n high, and sram_dq high-Z, including mid-transaction.
REQ-032 A write interrupted by reset SHALL leave the SRAM partially written; no recovery is required.

Structure
REQ-033 Shared package sram_pkg SHALL hold the state enum and the default DATA_W/SRAM_DW/SRAM_AW/WAIT_CYC constants.
REQ-034 Counters SHALL live in one sub-module, sram_beat_timer, with inputs clear and enable and outputs w, b, beat_last and xfer_last.
REQ-035 Elaboration SHALL fail if DATA_W % SRAM_DW != 0, BEATS is not a power of 2, or WAIT_CYC < 2.

Verification (defaults, SRAM behavioural model attached)
REQ-036 Write 0x1122334455667788 to addr 0x100 -> SRAM words 0x80..0x83 = 7788, 5566, 3344, 1122; ready pulses 1 cycle at cycle 13.
REQ-037 Read addr 0x104 after REQ-036 -> sram_addr 0x80..0x83, rd_data = 0x1122334455667788 at cycle 13, we_n never low.
REQ-038 rd_en=wr_en=1 at addr 0x100 -> read performed, sram_dq never driven, SRAM unchanged.
REQ-039 rst pulsed during write beat 2 -> same-cycle we_n=1, ce_n=1, dq=Z; ready=1 with no request; a following read completes in 13 cycles.
REQ-040 Read held through DONE -> exactly one IDLE cycle with ready=0, then a second 12-cycle READ; addr 0x3FFF8 with SRAM_AW=18 -> sram_addr 0x1FFFC..0x1FFFF.
